reg_wb_queue: RTL and testbench

Write-port driver for the 4x4-bit register file of the 4-bit CPU. It buffers register writeback requests from the datapath in a small FIFO and drives the register file's write select and write data every cycle. The register file writes on every clock and has no reset, so this block also provides three things:
- a zeroing sweep after reset;
- a value-preserving "refresh" write whenever no queued write may commit;
- forwarding of pending write data to readers.

---
 rtl/reg_wb_queue_if.sv | 10 +
 rtl/reg_wb_queue.sv | 132 +++++++++++++
 tb/tb_reg_wb_queue.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_wb_queue_if.sv
// Write-request channel from the datapath into the register-file writeback queue.
interface reg_wb_queue_if;
    logic       WR_VALID;
    logic [1:0] WR_SEL;
    logic [3:0] WR_DATA;
    logic       WR_READY;

    modport master (output WR_VALID, output WR_SEL, output WR_DATA, input WR_READY);
    modport slave  (input WR_VALID, input WR_SEL, input WR_DATA, output WR_READY);
endinterface

// File: rtl/reg_wb_queue.sv
// Write-port driver for the 4x4 register file: writeback FIFO, post-reset zeroing
// sweep, value-preserving refresh writes and forwarding of queued write data.
module reg_wb_queue #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    reg_wb_queue_if.slave wr,
    input  logic          WB_STALL,
    output logic [1:0]    RF_SEL_W,
    output logic [3:0]    RF_DATA,
    output logic [1:0]    RF_SEL_R,
    input  logic [3:0]    RF_OUT,
    input  logic [1:0]    FWD_SEL,
    output logic          FWD_HIT,
    output logic [3:0]    FWD_DATA,
    output logic [3:0]    PENDING,
    output logic [CW-1:0] COUNT,
    output logic          BUSY
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t        state_q, state_d;
    logic [1:0]    cp_q, cp_d;
    logic [1:0]    rp_q, rp_d;
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic [1:0]    sel_mem  [DEPTH];
    logic [3:0]    data_mem [DEPTH];
    logic          wr_ready_c;
    logic          pop_c;
    logic          push_c;
    logic          run_c;

    // State, pointers and occupancy; reset discards every queued entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cp_q    <= 2'd0;
            rp_q    <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cp_q    <= cp_d;
            rp_q    <= rp_d;
            if (push_c) tail_q <= tail_q + PW'(1);
            if (pop_c)  head_q <= head_q + PW'(1);
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Queue storage needs no reset; validity is tracked by head/count.
    always_ff @(posedge clk) begin
        if (push_c) begin
            sel_mem[tail_q]  <= wr.WR_SEL;
            data_mem[tail_q] <= wr.WR_DATA;
        end
    end

    // Next state and write-port drive: sweep, commit head, or refresh a register.
    always_comb begin
        state_d    = state_q;
        cp_d       = cp_q;
        rp_d       = rp_q;
        BUSY       = 1'b0;
        wr_ready_c = 1'b0;
        pop_c      = 1'b0;
        RF_SEL_W   = 2'd0;
        RF_DATA    = 4'd0;
        if (rst) begin
            BUSY = 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    BUSY     = 1'b1;
                    RF_SEL_W = cp_q;
                    cp_d     = cp_q + 2'd1;
                    if (cp_q == 2'd3) state_d = RUN;
                end
                RUN: begin
                    wr_ready_c = (count_q < CW'(DEPTH));
                    if ((count_q != '0) && !WB_STALL) begin
                        pop_c    = 1'b1;
                        RF_SEL_W = sel_mem[head_q];
                        RF_DATA  = data_mem[head_q];
                    end else begin
                        RF_SEL_W = rp_q;
                        RF_DATA  = RF_OUT;
                        rp_d     = rp_q + 2'd1;
                    end
                end
                default: state_d = CLEAR;
            endcase
        end
    end

    assign push_c      = wr.WR_VALID & wr_ready_c;
    assign run_c       = !rst && (state_q == RUN);
    assign wr.WR_READY = wr_ready_c;
    assign RF_SEL_R    = RF_SEL_W;
    assign COUNT       = count_q;

    // Scan oldest to youngest so the youngest matching entry wins the forward.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        FWD_HIT  = 1'b0;
        FWD_DATA = 4'd0;
        PENDING  = 4'd0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                PENDING[sel_mem[idx]] = 1'b1;
                if (run_c && (sel_mem[idx] == FWD_SEL)) begin
                    FWD_HIT  = 1'b1;
                    FWD_DATA = data_mem[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Randomized and directed bench for reg_wb_queue against a queue-based reference model
// plus a behavioural register file that captures the write port on every clock.
module tb_reg_wb_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          WB_STALL;
    logic [1:0]    RF_SEL_W;
    logic [3:0]    RF_DATA;
    logic [1:0]    RF_SEL_R;
    logic [3:0]    RF_OUT;
    logic [1:0]    FWD_SEL;
    logic          FWD_HIT;
    logic [3:0]    FWD_DATA;
    logic [3:0]    PENDING;
    logic [CW-1:0] COUNT;
    logic          BUSY;

    reg_wb_queue_if wr ();

    reg_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr),
        .WB_STALL (WB_STALL),
        .RF_SEL_W (RF_SEL_W),
        .RF_DATA  (RF_DATA),
        .RF_SEL_R (RF_SEL_R),
        .RF_OUT   (RF_OUT),
        .FWD_SEL  (FWD_SEL),
        .FWD_HIT  (FWD_HIT),
        .FWD_DATA (FWD_DATA),
        .PENDING  (PENDING),
        .COUNT    (COUNT),
        .BUSY     (BUSY)
    );

    always #5 clk = ~clk;

    // Register file: writes every clock, no reset.
    logic [3:0] rf [4];
    always @(posedge clk) rf[RF_SEL_W] <= RF_DATA;
    assign RF_OUT = rf[RF_SEL_R];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of pending writes, sweep progress, refresh pointer, register image.
    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] data;
    } ent_t;

    ent_t       mq [$];
    int         m_sweep = 0;
    int         m_rp    = 0;
    logic [3:0] m_rf [4];
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        bit   m_ready;
        bit   m_commit;
        ent_t e;
        if (rst) begin
            m_rf[0] = 4'd0;
            mq.delete();
            m_sweep = 0;
            m_rp    = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_sweep < 4) begin
                m_rf[m_sweep] = 4'd0;
                m_sweep++;
            end else begin
                m_ready  = (mq.size() < DEPTH);
                m_commit = (mq.size() > 0) && !WB_STALL;
                if (m_commit) begin
                    e = mq.pop_front();
                    m_rf[e.sel] = e.data;
                end else begin
                    m_rp = (m_rp + 1) % 4;
                end
                if (wr.WR_VALID && m_ready) mq.push_back({wr.WR_SEL, wr.WR_DATA});
            end
        end
    end

    // Per-cycle comparison of every output and the register image against the model.
    always @(negedge clk) begin
        int   e_busy, e_ready, e_sel, e_data, e_hit, e_fd, e_pend;
        if (m_valid) begin
            e_pend = 0;
            e_hit  = 0;
            e_fd   = 0;
            foreach (mq[k]) e_pend = e_pend | (1 << mq[k].sel);
            if (rst) begin
                e_busy = 1; e_ready = 0; e_sel = 0; e_data = 0;
            end else if (m_sweep < 4) begin
                e_busy = 1; e_ready = 0; e_sel = m_sweep; e_data = 0;
            end else begin
                e_busy  = 0;
                e_ready = (mq.size() < DEPTH) ? 1 : 0;
                if (mq.size() > 0 && !WB_STALL) begin
                    e_sel  = int'(mq[0].sel);
                    e_data = int'(mq[0].data);
                end else begin
                    e_sel  = m_rp;
                    e_data = int'(m_rf[m_rp]);
                end
                foreach (mq[k]) begin
                    if (mq[k].sel == FWD_SEL) begin
                        e_hit = 1;
                        e_fd  = int'(mq[k].data);
                    end
                end
            end
            check("busy",     int'(BUSY),        e_busy);
            check("wr_ready", int'(wr.WR_READY), e_ready);
            check("rf_sel_w", int'(RF_SEL_W),    e_sel);
            check("rf_sel_r", int'(RF_SEL_R),    e_sel);
            check("rf_data",  int'(RF_DATA),     e_data);
            check("count",    int'(COUNT),       mq.size());
            check("pending",  int'(PENDING),     e_pend);
            check("fwd_hit",  int'(FWD_HIT),     e_hit);
            check("fwd_data", int'(FWD_DATA),    e_fd);
            if (m_sweep == 4) begin
                for (int r = 0; r < 4; r++) check($sformatf("rf%0d", r), int'(rf[r]), int'(m_rf[r]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_set(input logic [1:0] s, input logic [3:0] d);
        wr.WR_VALID = 1'b1;
        wr.WR_SEL   = s;
        wr.WR_DATA  = d;
    endtask

    initial begin
        int first;
        rst         = 1'b1;
        wr.WR_VALID = 1'b0;
        wr.WR_SEL   = 2'd0;
        wr.WR_DATA  = 4'd0;
        WB_STALL    = 1'b0;
        FWD_SEL     = 2'd0;

        // Reset sweep
        step(); step();
        #1;
        check("rst_busy", int'(BUSY), 1);
        check("rst_ready", int'(wr.WR_READY), 0);
        check("rst_sel", int'(RF_SEL_W), 0);
        check("rst_data", int'(RF_DATA), 0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("sweep_busy", int'(BUSY), 1);
            check("sweep_sel", int'(RF_SEL_W), c);
            check("sweep_data", int'(RF_DATA), 0);
            check("sweep_ready", int'(wr.WR_READY), 0);
            step();
        end
        #1;
        check("run_ready", int'(wr.WR_READY), 1);
        check("run_busy", int'(BUSY), 0);
        for (int r = 0; r < 4; r++) check("swept_zero", int'(rf[r]), 0);

        // Single write
        push_set(2'd2, 4'hA);
        step();
        wr.WR_VALID = 1'b0;
        #1;
        check("single_sel", int'(RF_SEL_W), 2);
        check("single_data", int'(RF_DATA), 10);
        check("single_pend", int'(PENDING), 4);
        check("single_cnt", int'(COUNT), 1);
        step();
        #1;
        check("single_r2", int'(rf[2]), 10);
        check("single_cnt0", int'(COUNT), 0);
        check("single_pend0", int'(PENDING), 0);

        // Stall fill
        WB_STALL = 1'b1;
        push_set(2'd1, 4'd3); step();
        push_set(2'd1, 4'd5); step();
        push_set(2'd0, 4'd7); step();
        push_set(2'd3, 4'd9); step();
        wr.WR_VALID = 1'b0;
        FWD_SEL     = 2'd1;
        #1;
        check("fill_cnt", int'(COUNT), 4);
        check("fill_ready", int'(wr.WR_READY), 0);
        check("fill_pend", int'(PENDING), 11);
        check("fill_hit", int'(FWD_HIT), 1);
        check("fill_fwd", int'(FWD_DATA), 5);
        WB_STALL = 1'b0;
        repeat (4) step();
        #1;
        check("drain_r1", int'(rf[1]), 5);
        check("drain_r0", int'(rf[0]), 7);
        check("drain_r3", int'(rf[3]), 9);
        check("drain_cnt", int'(COUNT), 0);

        // Concurrent push/pop at COUNT = 3
        WB_STALL = 1'b1;
        repeat (3) begin
            push_set(2'($urandom_range(3)), 4'($urandom_range(15)));
            step();
        end
        WB_STALL = 1'b0;
        repeat (6) begin
            push_set(2'($urandom_range(3)), 4'($urandom_range(15)));
            #1;
            check("conc_cnt", int'(COUNT), 3);
            step();
        end
        // Full with a held request
        WB_STALL = 1'b1;
        push_set(2'd1, 4'd6);
        step();
        push_set(2'd0, 4'hE);
        #1;
        check("full_ready", int'(wr.WR_READY), 0);
        check("full_cnt", int'(COUNT), 4);
        step();
        WB_STALL = 1'b0;
        #1;
        check("full_ready2", int'(wr.WR_READY), 0);
        step();
        #1;
        check("refill_ready", int'(wr.WR_READY), 1);
        check("refill_cnt", int'(COUNT), 3);
        step();
        wr.WR_VALID = 1'b0;
        repeat (6) step();
        #1;
        check("held_r0", int'(rf[0]), 14);
        check("held_cnt", int'(COUNT), 0);

        // Forward miss and refresh rotation
        FWD_SEL = 2'd2;
        #1;
        check("miss_hit", int'(FWD_HIT), 0);
        check("miss_data", int'(FWD_DATA), 0);
        first = int'(RF_SEL_W);
        for (int k = 0; k < 8; k++) begin
            check("refresh_sel", int'(RF_SEL_W), (first + k) % 4);
            step();
            #1;
        end

        // Reset mid-operation with stalled entries
        WB_STALL = 1'b1;
        push_set(2'd1, 4'hF); step();
        push_set(2'd2, 4'hF); step();
        push_set(2'd3, 4'hF); step();
        wr.WR_VALID = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("mid_pend", int'(PENDING), 0);
        check("mid_cnt", int'(COUNT), 0);
        check("mid_busy", int'(BUSY), 1);
        repeat (4) step();
        WB_STALL = 1'b0;
        #1;
        check("mid_ready", int'(wr.WR_READY), 1);
        for (int r = 0; r < 4; r++) check("mid_zero", int'(rf[r]), 0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 800; n++) begin
            wr.WR_VALID = 1'($urandom_range(1));
            wr.WR_SEL   = 2'($urandom_range(3));
            wr.WR_DATA  = 4'($urandom_range(15));
            WB_STALL    = ($urandom_range(9) < 4);
            FWD_SEL     = 2'($urandom_range(3));
            rst         = ($urandom_range(199) == 0);
            step();
        end
        rst         = 1'b0;
        wr.WR_VALID = 1'b0;
        WB_STALL    = 1'b0;
        repeat (12) step();
        #1;
        check("final_cnt", int'(COUNT), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
